// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and defaults for the sequential multiply/divide unit
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic MDU_MULT = 1'b0;
  localparam logic MDU_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one Booth (MULT) or restoring-division (DIV) iteration on the accumulator
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               op,
  input  logic [2*WIDTH+1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH+1:0] acc_nx
);
  logic [WIDTH:0] upper, sum, rem_sh, dvs;
  logic fits;
  // MULT keeps a guard bit above the upper half so subtracting the most negative multiplicand cannot overflow
  always_comb begin
    upper  = acc[2*WIDTH+1:WIDTH+1];
    sum    = acc[1:0] == 2'b01 ? upper + {opnd[WIDTH-1], opnd} :
             acc[1:0] == 2'b10 ? upper - {opnd[WIDTH-1], opnd} : upper;
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    dvs    = {1'b0, opnd};
    fits   = rem_sh >= dvs;
    acc_nx = op == MDU_MULT ? {sum[WIDTH], sum, acc[WIDTH:1]}
                            : {1'b0, fits ? rem_sh - dvs : rem_sh, acc[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential signed MULT/DIV unit producing HI/LO results
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int AW = 2*WIDTH+2;
  state_t state;
  logic op_r, sign_q, sign_r;
  logic [WIDTH-1:0] opnd, a_abs, b_abs, q_res, r_res;
  logic [AW-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt;
  mdu_step #(.WIDTH(WIDTH)) u_step (.op(op_r), .acc(acc), .opnd(opnd), .acc_nx(acc_nx));
  always_comb begin
    a_abs = a[WIDTH-1] ? -a : a;
    b_abs = b[WIDTH-1] ? -b : b;
    q_res = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_res = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op_r     <= MDU_MULT;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r     <= op;
          div_zero <= 1'b0;
          if (op == MDU_DIV && b == '0) begin
            state    <= DONE;
            div_zero <= 1'b1;
            done     <= 1'b1;
          end else begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            opnd   <= op == MDU_DIV ? b_abs : b;
            acc    <= op == MDU_DIV ? {{(WIDTH+2){1'b0}}, a_abs} : {{(WIDTH+1){1'b0}}, a, 1'b0};
            sign_r <= a[WIDTH-1];
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          hi    <= op_r == MDU_DIV ? r_res : acc[2*WIDTH:WIDTH+1];
          lo    <= op_r == MDU_DIV ? q_res : acc[WIDTH:1];
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed self-checking bench for mult_div_seq
module tb_mult_div_seq;
  logic clk, rst, start, op, busy, done, div_zero;
  logic [31:0] a, b, hi, lo;
  int checks = 0, passed = 0;

  mult_div_seq dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // edges counts the start edge plus every edge until done is seen (bounded at 100)
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output int edges, output int busy_cyc);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; edges = 1; busy_cyc = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 0; start = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
    checks++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_zero); else passed++;
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int e, bc;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, e, bc);
    checks++; if (e !== 34) $display("FAIL mult_latency got %0d want 34", e); else passed++;
    checks++; if (bc !== 33) $display("FAIL mult_busy got %0d want 33", bc); else passed++;
    checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else passed++;
    checks++; if (lo !== 32'hFFFFFFEB) $display("FAIL mult_lo got %h want ffffffeb", lo); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done got %b want 0", busy); else passed++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL mult_done_pulse got %b want 0", done); else passed++;
  endtask

  task automatic test_div;
    int e, bc;
    run_op(1'b1, 32'hFFFFFFEF, 32'd5, e, bc);
    checks++; if (e !== 34) $display("FAIL div_latency got %0d want 34", e); else passed++;
    checks++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo got %h want fffffffd", lo); else passed++;
    checks++; if (hi !== 32'hFFFFFFFE) $display("FAIL div_hi got %h want fffffffe", hi); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL div_dz got %b want 0", div_zero); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int e, bc;
    run_op(1'b1, 32'd100, 32'd0, e, bc);
    checks++; if (e !== 1) $display("FAIL dz_latency got %0d want 1", e); else passed++;
    checks++; if (div_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", div_zero); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL dz_busy got %b want 0", busy); else passed++;
    checks++; if (hi !== 32'hFFFFFFFE) $display("FAIL dz_hi_kept got %h want fffffffe", hi); else passed++;
    checks++; if (lo !== 32'hFFFFFFFD) $display("FAIL dz_lo_kept got %h want fffffffd", lo); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (div_zero !== 1'b1) $display("FAIL dz_sticky got %b want 1", div_zero); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL dz_done_pulse got %b want 0", done); else passed++;
  endtask

  task automatic test_corners;
    int e, bc;
    run_op(1'b0, 32'h80000000, 32'h80000000, e, bc);
    checks++; if (hi !== 32'h40000000) $display("FAIL cmul_hi got %h want 40000000", hi); else passed++;
    checks++; if (lo !== 32'h0) $display("FAIL cmul_lo got %h want 0", lo); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL cmul_dz_cleared got %b want 0", div_zero); else passed++;
    @(posedge clk); #1;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, e, bc);
    checks++; if (lo !== 32'h80000000) $display("FAIL cdiv_lo got %h want 80000000", lo); else passed++;
    checks++; if (hi !== 32'h0) $display("FAIL cdiv_hi got %h want 0", hi); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL cdiv_dz got %b want 0", div_zero); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int e, nd;
    start = 1; op = 0; a = 32'd12; b = 32'd12;
    @(posedge clk); #1;
    start = 0; e = 1; nd = 0;
    repeat (45) begin
      if (e == 10) begin start = 1; op = 1; a = 32'd1; b = 32'd0; end
      else start = 0;
      @(posedge clk); #1;
      e++;
      if (done) nd++;
    end
    start = 0;
    checks++; if (nd !== 1) $display("FAIL b2b_done_count got %0d want 1", nd); else passed++;
    checks++; if (lo !== 32'd144) $display("FAIL b2b_lo got %0d want 144", lo); else passed++;
    checks++; if (hi !== 32'h0) $display("FAIL b2b_hi got %h want 0", hi); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL b2b_dz got %b want 0", div_zero); else passed++;
  endtask

  task automatic test_reset_mid;
    int e, bc, nd;
    start = 1; op = 1; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (14) @(posedge clk);
    #1;
    rst = 0;
    #1;
    checks++; if (hi !== 32'h0) $display("FAIL rmid_hi got %h want 0", hi); else passed++;
    checks++; if (lo !== 32'h0) $display("FAIL rmid_lo got %h want 0", lo); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
    @(posedge clk); #1;
    rst = 1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++; if (nd !== 0) $display("FAIL rmid_no_done got %0d want 0", nd); else passed++;
    run_op(1'b1, 32'd9, 32'd2, e, bc);
    checks++; if (e !== 34) $display("FAIL rmid_div_latency got %0d want 34", e); else passed++;
    checks++; if (lo !== 32'd4) $display("FAIL rmid_div_lo got %h want 4", lo); else passed++;
    checks++; if (hi !== 32'd1) $display("FAIL rmid_div_hi got %h want 1", hi); else passed++;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_corners;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
